// File: rtl/w_stage_pkg.sv
// Shared CPU constants: writeback source and load type encodings.
package w_stage_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC8 = 2'd2,
        WB_RSV = 2'd3
    } wbsel_e;

    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LB  = 3'd1,
        LD_LBU = 3'd2,
        LD_LH  = 3'd3,
        LD_LHU = 3'd4
    } loadtype_e;

    localparam logic [31:0] PC_LINK_OFFSET = 32'd8;

endpackage

// File: rtl/w_stage_if.sv
// M-to-W stage bundle: M-stage slot inputs and registered W-stage outputs.
interface w_stage_if;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [4:0]  m_a3;
    logic        m_regwrite;
    logic [1:0]  m_wbsel;
    logic [31:0] m_aluout;
    logic [31:0] m_memword;
    logic [2:0]  m_loadtype;
    logic [1:0]  m_byteaddr;

    logic        w_valid;
    logic [31:0] w_pc;
    logic [4:0]  w_a3;
    logic        w_regwrite;
    logic [31:0] w_writedata;
    logic [31:0] retire_cnt;

    modport master (
        output m_valid, m_pc, m_a3, m_regwrite, m_wbsel, m_aluout,
               m_memword, m_loadtype, m_byteaddr,
        input  w_valid, w_pc, w_a3, w_regwrite, w_writedata, retire_cnt
    );

    modport slave (
        input  m_valid, m_pc, m_a3, m_regwrite, m_wbsel, m_aluout,
               m_memword, m_loadtype, m_byteaddr,
        output w_valid, w_pc, w_a3, w_regwrite, w_writedata, retire_cnt
    );
endinterface

// File: rtl/w_stage_load_ext.sv
// Load extension: picks the addressed byte/half of the DM word and extends it.
module load_ext
    import w_stage_pkg::*;
(
    input  logic [31:0] m_memword,
    input  logic [1:0]  m_byteaddr,
    input  logic [2:0]  m_loadtype,
    output logic [31:0] result
);
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = m_memword[7:0];
        case (m_byteaddr)
            2'd0:    sel_byte = m_memword[7:0];
            2'd1:    sel_byte = m_memword[15:8];
            2'd2:    sel_byte = m_memword[23:16];
            default: sel_byte = m_memword[31:24];
        endcase
        sel_half = m_byteaddr[1] ? m_memword[31:16] : m_memword[15:0];

        // Unused encodings 5-7 fall through to a full-word load.
        case (m_loadtype)
            LD_LB:   result = {{24{sel_byte[7]}}, sel_byte};
            LD_LBU:  result = {24'd0, sel_byte};
            LD_LH:   result = {{16{sel_half[15]}}, sel_half};
            LD_LHU:  result = {16'd0, sel_half};
            default: result = m_memword;
        endcase
    end
endmodule

// File: rtl/w_stage.sv
// W pipeline register: captures the M-stage slot, resolves writeback data, counts retirements.
module w_stage
    import w_stage_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic       flush,
    w_stage_if.slave   bus
);
    logic [31:0] load_data;
    logic [31:0] wb_data;

    logic        r_valid;
    logic [31:0] r_pc;
    logic [4:0]  r_a3;
    logic        r_regwrite;
    logic [31:0] r_writedata;
    logic [31:0] r_retire;

    load_ext u_load_ext (
        .m_memword  (bus.m_memword),
        .m_byteaddr (bus.m_byteaddr),
        .m_loadtype (bus.m_loadtype),
        .result     (load_data)
    );

    always_comb begin
        wb_data = '0;
        case (wbsel_e'(bus.m_wbsel))
            WB_ALU:  wb_data = bus.m_aluout;
            WB_MEM:  wb_data = load_data;
            WB_PC8:  wb_data = bus.m_pc + PC_LINK_OFFSET;
            default: wb_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_a3        <= '0;
            r_regwrite  <= 1'b0;
            r_writedata <= '0;
            r_retire    <= '0;
        end else if (flush) begin
            // Bubble insertion; the retire count is left alone.
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_a3        <= '0;
            r_regwrite  <= 1'b0;
            r_writedata <= '0;
        end else if (!stall) begin
            r_valid     <= bus.m_valid;
            r_pc        <= bus.m_valid ? bus.m_pc : '0;
            r_a3        <= bus.m_valid ? bus.m_a3 : '0;
            r_regwrite  <= bus.m_regwrite & bus.m_valid & (bus.m_a3 != 5'd0);
            r_writedata <= wb_data;
            if (bus.m_valid)
                r_retire <= r_retire + 32'd1;
        end
    end

    assign bus.w_valid     = r_valid;
    assign bus.w_pc        = r_pc;
    assign bus.w_a3        = r_a3;
    assign bus.w_regwrite  = r_regwrite;
    assign bus.w_writedata = r_writedata;
    assign bus.retire_cnt  = r_retire;
endmodule

// File: tb/tb_w_stage.sv
// Bench for w_stage: directed literal cases plus randomized traffic against a behavioural model.
module tb_w_stage;
    logic clk = 1'b0;
    logic reset, stall, flush;
    int unsigned total = 0;
    int unsigned bad = 0;

    w_stage_if ifc ();

    w_stage dut (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .flush (flush),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          mok = 1'b0;
    logic        e_valid, e_rw;
    logic [31:0] e_pc, e_wd, e_cnt;
    logic [4:0]  e_a3;

    function automatic logic [31:0] model_load(logic [31:0] word, logic [1:0] ba, logic [2:0] lt);
        logic [31:0] v;
        if (lt == 3'd1 || lt == 3'd2) begin
            v = (word >> (8 * ba)) & 32'hFF;
            if (lt == 3'd1 && v > 32'd127) v = v + 32'hFFFFFF00;
        end else if (lt == 3'd3 || lt == 3'd4) begin
            v = (word >> (16 * ba[1])) & 32'hFFFF;
            if (lt == 3'd3 && v > 32'd32767) v = v + 32'hFFFF0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_wd();
        case (ifc.m_wbsel)
            2'd0:    return ifc.m_aluout;
            2'd1:    return model_load(ifc.m_memword, ifc.m_byteaddr, ifc.m_loadtype);
            2'd2:    return ifc.m_pc + 32'd8;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mok = 1'b1;
            e_valid = 0; e_rw = 0; e_pc = 0; e_a3 = 0; e_wd = 0; e_cnt = 0;
        end else if (flush) begin
            e_valid = 0; e_rw = 0; e_pc = 0; e_a3 = 0; e_wd = 0;
        end else if (!stall) begin
            e_valid = ifc.m_valid;
            e_pc    = ifc.m_valid ? ifc.m_pc : 32'd0;
            e_a3    = ifc.m_valid ? ifc.m_a3 : 5'd0;
            e_rw    = ifc.m_regwrite && ifc.m_valid && ifc.m_a3 != 5'd0;
            e_wd    = model_wd();
            if (ifc.m_valid) e_cnt = e_cnt + 32'd1;
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mok) begin
            chk("m.w_valid",     32'(ifc.w_valid),    32'(e_valid));
            chk("m.w_pc",        ifc.w_pc,            e_pc);
            chk("m.w_a3",        32'(ifc.w_a3),       32'(e_a3));
            chk("m.w_regwrite",  32'(ifc.w_regwrite), 32'(e_rw));
            chk("m.w_writedata", ifc.w_writedata,     e_wd);
            chk("m.retire_cnt",  ifc.retire_cnt,      e_cnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(logic v, logic [31:0] pc, logic [4:0] a3, logic rw, logic [1:0] wb,
                         logic [31:0] alu, logic [31:0] mem, logic [2:0] lt, logic [1:0] ba);
        ifc.m_valid = v; ifc.m_pc = pc; ifc.m_a3 = a3; ifc.m_regwrite = rw;
        ifc.m_wbsel = wb; ifc.m_aluout = alu; ifc.m_memword = mem;
        ifc.m_loadtype = lt; ifc.m_byteaddr = ba;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        set_m(1, 32'h1000, 5'd7, 1, 2'd0, 32'hDEAD, 32'h0, 3'd0, 2'd0);
        tick(); tick();
        chk("rst.w_valid", 32'(ifc.w_valid), 32'd0);
        chk("rst.retire",  ifc.retire_cnt,   32'd0);
        reset = 1'b0;

        // lb, byte 2 of 0x80FF7F01 = 0xFF sign-extended
        set_m(1, 32'h100, 5'd5, 1, 2'd1, 32'h0, 32'h80FF7F01, 3'd1, 2'd2);
        tick();
        chk("lb.wd", ifc.w_writedata, 32'hFFFFFFFF);
        chk("lb.rw", 32'(ifc.w_regwrite), 32'd1);
        chk("lb.a3", 32'(ifc.w_a3), 32'd5);
        chk("lb.cnt", ifc.retire_cnt, 32'd1);

        set_m(1, 32'h104, 5'd5, 1, 2'd1, 32'h0, 32'h80FF7F01, 3'd4, 2'd3);
        tick();
        chk("lhu.wd", ifc.w_writedata, 32'h000080FF);

        set_m(1, 32'h00003000, 5'd31, 1, 2'd2, 32'h0, 32'h0, 3'd0, 2'd0);
        tick();
        chk("jal.wd", ifc.w_writedata, 32'h00003008);
        chk("jal.a3", 32'(ifc.w_a3), 32'd31);
        set_m(1, 32'hFFFFFFFC, 5'd31, 1, 2'd2, 32'h0, 32'h0, 3'd0, 2'd0);
        tick();
        chk("jalwrap.wd", ifc.w_writedata, 32'h00000004);
        chk("jalwrap.cnt", ifc.retire_cnt, 32'd4);

        stall = 1'b1;
        set_m(1, 32'h55, 5'd9, 1, 2'd0, 32'h77, 32'h0, 3'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.pc",  ifc.w_pc, 32'hFFFFFFFC);
            chk("stall.wd",  ifc.w_writedata, 32'h00000004);
            chk("stall.cnt", ifc.retire_cnt, 32'd4);
        end
        flush = 1'b1;
        tick();
        chk("fs.valid", 32'(ifc.w_valid), 32'd0);
        chk("fs.rw",    32'(ifc.w_regwrite), 32'd0);
        chk("fs.pc",    ifc.w_pc, 32'd0);
        chk("fs.cnt",   ifc.retire_cnt, 32'd4);
        stall = 1'b0; flush = 1'b0;

        set_m(1, 32'h200, 5'd0, 1, 2'd0, 32'h1234, 32'h0, 3'd0, 2'd0);
        tick();
        chk("zr.rw",  32'(ifc.w_regwrite), 32'd0);
        chk("zr.wd",  ifc.w_writedata, 32'h1234);
        chk("zr.cnt", ifc.retire_cnt, 32'd5);

        stall = 1'b1; reset = 1'b1;
        set_m(1, 32'h300, 5'd3, 1, 2'd0, 32'hABCD, 32'h0, 3'd0, 2'd0);
        tick();
        chk("rmid.valid", 32'(ifc.w_valid), 32'd0);
        chk("rmid.pc",    ifc.w_pc, 32'd0);
        chk("rmid.wd",    ifc.w_writedata, 32'd0);
        chk("rmid.cnt",   ifc.retire_cnt, 32'd0);
        stall = 1'b0; reset = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 4) == 0);
            set_m(1'($urandom_range(0, 3) != 0), $urandom(), 5'($urandom()),
                  1'($urandom()), 2'($urandom()), $urandom(), $urandom(),
                  3'($urandom()), 2'($urandom()));
            tick();
        end
        reset = 1'b0; flush = 1'b0; stall = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/w_stage.md
W_STAGE -- requirements
Module: w_stage

Interface
REQ-001 SHALL have clk  input  1  clock; all state updates on its rising edge.
REQ-002 SHALL have reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have stall  input  1  hold the register contents this cycle.
REQ-004 SHALL have flush  input  1  load a bubble this cycle.
REQ-005 SHALL have m_valid  input  1  the M-stage slot holds a real instruction.
REQ-006 SHALL have m_pc  input  32  PC of the M-stage instruction.
REQ-007 SHALL have m_a3  input  5  destination register number.
REQ-008 SHALL have m_regwrite  input  1  the instruction writes the GRF.
REQ-009 SHALL have m_wbsel  input  2  writeback source: 0 ALU, 1 memory, 2 PC+8, 3 reserved.
REQ-010 SHALL have m_aluout  input  32  ALU result.
REQ-011 SHALL have m_memword  input  32  raw aligned word read from the DM.
REQ-012 SHALL have m_loadtype  input  3  load type: 0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu.
REQ-013 SHALL have m_byteaddr  input  2  low two bits of the load address.
REQ-014 SHALL have w_valid, w_pc[31:0], w_a3[4:0], w_regwrite, w_writedata[31:0]  output  registered GRF write port and trace info.
REQ-015 SHALL have retire_cnt  output  32  count of instructions retired since reset.

Function
REQ-016 SHALL register all outputs, giving one cycle of latency from the M inputs to the W outputs.
REQ-017 SHALL apply update priority reset > flush > stall > load.
REQ-018 SHALL, on flush, clear w_valid, w_regwrite, w_a3, w_pc and w_writedata to 0 at the next edge.
REQ-019 SHALL, on stall without flush, hold all registered outputs and retire_cnt unchanged.
REQ-020 SHALL, on load, capture w_regwrite as m_regwrite & m_valid & (m_a3 != 0).
REQ-021 SHALL select w_writedata by m_wbsel: ALU gives m_aluout; memory gives the extended load; PC+8 gives m_pc + 8 with wrap-around modulo 2^32; reserved gives 0.
REQ-022 SHALL perform load extension as follows:
  - lw passes the whole word and ignores m_byteaddr.
  - lb/lbu select byte m_byteaddr (byte 0 = bits 7:0) and sign- or zero-extend it.
  - lh/lhu select the half given by m_byteaddr[1] (0 = bits 15:0) and ignore m_byteaddr[0].
REQ-023 SHALL treat m_loadtype values 5–7 as lw.
REQ-024 SHALL capture w_pc and w_a3 unchanged when m_valid=1, and 0 when m_valid=0.
REQ-025 SHALL increment retire_cnt by 1 on each load edge with m_valid=1, wrapping from 0xFFFFFFFF to 0.
REQ-026 SHALL NOT increment retire_cnt on reset, flush or stall edges.
REQ-027 SHALL cause a flush asserted together with stall to load a bubble and leave retire_cnt unchanged.

Reset
REQ-028 SHALL, on reset, set every output and retire_cnt to 0 at the next rising edge, regardless of stall and flush.
REQ-029 SHALL discard an M instruction presented in the same cycle as reset.

Structure
REQ-030 SHALL take the wbsel and loadtype encodings from the shared CPU constants package used by the controller and M stage.
REQ-031 SHALL place load extension in one combinational sub-module, load_ext (m_memword, m_byteaddr, m_loadtype -> 32-bit result).
REQ-032 SHALL connect w_a3, w_writedata, w_regwrite and w_pc directly to the GRF write port, with no further logic.

Verification
REQ-033 SHALL cover lb: m_memword=0x80FF7F01, m_byteaddr=2, loadtype lb, wbsel=1, a3=5 -> next cycle w_writedata=0xFFFFFFFF, w_regwrite=1, w_a3=5.
REQ-034 SHALL cover lhu: same word, m_byteaddr=3, loadtype lhu -> w_writedata=0x000080FF.
REQ-035 SHALL cover jal: wbsel=2, m_pc=0x00003000, a3=31 -> w_writedata=0x00003008; also m_pc=0xFFFFFFFC -> 0x00000004.
REQ-036 SHALL cover stall/flush: stall for 3 cycles after a retire -> outputs and retire_cnt frozen; then flush+stall together -> w_valid=0, w_regwrite=0, retire_cnt unchanged.
REQ-037 SHALL cover the zero register: m_regwrite=1, m_a3=0, m_valid=1 -> w_regwrite=0 while retire_cnt still increments.
REQ-038 SHALL cover reset mid-stream: assert reset while m_valid=1 with stall=1 -> all outputs and retire_cnt = 0 after the edge.
